// File: rtl/uart_pkg.sv
// Shared types and constants for the UART register loader: RX and framer state encodings.
package uart_pkg;

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} rx_state_t;
    typedef enum logic {WAIT_ADDR, WAIT_DATA} frm_state_t;

    localparam int ADDR_MARK_BIT = 7;

    // Rounded clock divider producing OVERSAMPLE ticks per bit period.
    function automatic int calc_div(input int clk_freq, input int baud, input int os);
        return (clk_freq + (baud * os) / 2) / (baud * os);
    endfunction

endpackage

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver: 2-FF input synchronizer, oversampling tick divider and deframing FSM.
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD       = 115200,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       busy,
    output logic [2:0] rx_state
);

    localparam int DIV = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
    localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int OW  = $clog2(OVERSAMPLE);
    localparam logic [DW-1:0] DIV_LAST  = DW'(DIV - 1);
    localparam logic [OW-1:0] OS_LAST   = OW'(OVERSAMPLE - 1);
    localparam logic [OW-1:0] HALF_LAST = OW'(OVERSAMPLE / 2 - 1);

    logic          rx_meta, rx_sync;
    logic [DW-1:0] div_cnt;
    logic          tick;
    rx_state_t     state, state_n;
    logic [OW-1:0] os_cnt, os_n;
    logic [2:0]    bit_cnt, bit_n;
    logic [7:0]    shift, shift_n;
    logic [7:0]    data_n;
    logic          valid_n, ferr_n;

    assign tick     = (div_cnt == DIV_LAST);
    assign busy     = (state != IDLE);
    assign rx_state = state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta   <= 1'b1;
            rx_sync   <= 1'b1;
            div_cnt   <= '0;
            state     <= IDLE;
            os_cnt    <= '0;
            bit_cnt   <= '0;
            shift     <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_meta   <= rx;
            rx_sync   <= rx_meta;
            div_cnt   <= tick ? '0 : div_cnt + 1'b1;
            state     <= state_n;
            os_cnt    <= os_n;
            bit_cnt   <= bit_n;
            shift     <= shift_n;
            rx_data   <= data_n;
            rx_valid  <= valid_n;
            frame_err <= ferr_n;
        end
    end

    // Sampling points are counted in ticks from the start-bit edge: mid-start, then one bit apart.
    always_comb begin
        state_n = state;
        os_n    = os_cnt;
        bit_n   = bit_cnt;
        shift_n = shift;
        data_n  = rx_data;
        valid_n = 1'b0;
        ferr_n  = 1'b0;
        if (tick) begin
            case (state)
                IDLE: begin
                    if (!rx_sync) begin
                        state_n = START;
                        os_n    = '0;
                    end
                end
                START: begin
                    if (os_cnt == HALF_LAST) begin
                        os_n    = '0;
                        bit_n   = '0;
                        state_n = rx_sync ? IDLE : DATA;
                    end else begin
                        os_n = os_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (os_cnt == OS_LAST) begin
                        os_n    = '0;
                        shift_n = {rx_sync, shift[7:1]};
                        bit_n   = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) state_n = STOP;
                    end else begin
                        os_n = os_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (os_cnt == OS_LAST) begin
                        os_n = '0;
                        if (rx_sync) begin
                            data_n  = shift;
                            valid_n = 1'b1;
                            state_n = IDLE;
                        end else begin
                            ferr_n  = 1'b1;
                            state_n = BRK;
                        end
                    end else begin
                        os_n = os_cnt + 1'b1;
                    end
                end
                BRK: begin
                    if (rx_sync) state_n = IDLE;
                end
                default: state_n = IDLE;
            endcase
        end
    end

endmodule

// File: rtl/uart_reg_loader.sv
// Turns two-byte UART commands {addr(bit7 set), data} into single-cycle register-file writes.
module uart_reg_loader
    import uart_pkg::*;
#(
    parameter int CLK_FREQ    = 50_000_000,
    parameter int BAUD        = 115200,
    parameter int OVERSAMPLE  = 16,
    parameter int TIMEOUT_CYC = 5_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic       we3,
    output logic [2:0] wa3,
    output logic [7:0] wd3,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       busy,
    output logic [2:0] rx_state,
    output logic       frm_state
);

    localparam int TW = $clog2(TIMEOUT_CYC);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);

    frm_state_t    frm, frm_n;
    logic [2:0]    addr, addr_n;
    logic [TW-1:0] to_cnt, to_n;
    logic          we3_n;
    logic [2:0]    wa3_n;
    logic [7:0]    wd3_n;

    // rx_valid/frame_err are single-cycle pulses with no back-pressure; rx_data is valid
    // in the same cycle as rx_valid and held afterwards. we3 follows one cycle later.
    uart_rx_core #(
        .CLK_FREQ  (CLK_FREQ),
        .BAUD      (BAUD),
        .OVERSAMPLE(OVERSAMPLE)
    ) u_rx (
        .clk      (clk),
        .rst      (rst),
        .rx       (rx),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .frame_err(frame_err),
        .busy     (busy),
        .rx_state (rx_state)
    );

    assign frm_state = frm;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frm    <= WAIT_ADDR;
            addr   <= '0;
            to_cnt <= '0;
            we3    <= 1'b0;
            wa3    <= '0;
            wd3    <= '0;
        end else begin
            frm    <= frm_n;
            addr   <= addr_n;
            to_cnt <= to_n;
            we3    <= we3_n;
            wa3    <= wa3_n;
            wd3    <= wd3_n;
        end
    end

    // A data byte takes priority over a coincident timeout or frame error.
    always_comb begin
        frm_n  = frm;
        addr_n = addr;
        to_n   = to_cnt;
        we3_n  = 1'b0;
        wa3_n  = wa3;
        wd3_n  = wd3;
        case (frm)
            WAIT_ADDR: begin
                if (rx_valid && rx_data[ADDR_MARK_BIT]) begin
                    addr_n = rx_data[2:0];
                    to_n   = '0;
                    frm_n  = WAIT_DATA;
                end
            end
            WAIT_DATA: begin
                if (rx_valid) begin
                    we3_n = 1'b1;
                    wa3_n = addr;
                    wd3_n = rx_data;
                    frm_n = WAIT_ADDR;
                end else if (frame_err) begin
                    frm_n = WAIT_ADDR;
                end else if (to_cnt == TO_LAST) begin
                    frm_n = WAIT_ADDR;
                end else begin
                    to_n = to_cnt + 1'b1;
                end
            end
            default: frm_n = WAIT_ADDR;
        endcase
    end

endmodule

// File: tb/tb_uart_reg_loader.sv
// Bench for uart_reg_loader: serial driver, event-queue reference model and per-cycle compare.
module tb_uart_reg_loader;

    localparam int CLK_FREQ = 1_600_000;
    localparam int BAUD     = 10_000;
    localparam int OS       = 16;
    localparam int TO       = 4000;
    localparam int BIT_CLK  = CLK_FREQ / BAUD;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rx  = 1'b1;
    logic       we3;
    logic [2:0] wa3;
    logic [7:0] wd3;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       busy;
    logic [2:0] rx_state;
    logic       frm_state;

    always #5 clk = ~clk;

    uart_reg_loader #(
        .CLK_FREQ   (CLK_FREQ),
        .BAUD       (BAUD),
        .OVERSAMPLE (OS),
        .TIMEOUT_CYC(TO)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rx       (rx),
        .we3      (we3),
        .wa3      (wa3),
        .wd3      (wd3),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .frame_err(frame_err),
        .busy     (busy),
        .rx_state (rx_state),
        .frm_state(frm_state)
    );

    int checks = 0;
    int fails  = 0;

    // Expected receive events in send order: bit 8 set = frame error, else a good byte.
    logic [8:0] exp_q[$];

    logic       exp_we3     = 1'b0;
    logic [2:0] exp_wa3     = '0;
    logic [7:0] exp_wd3     = '0;
    logic [7:0] exp_rx_data = '0;
    bit         m_wait      = 1'b0;
    logic [2:0] m_addr      = '0;
    int         m_since     = 0;
    int         n_valid     = 0;
    int         n_err       = 0;
    int         n_write     = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        logic [8:0] ev;
        if (!rst) begin
            chk("reset_outputs", {9'd0, we3, wa3, wd3, rx_data, rx_valid, frame_err, busy}, 32'd0);
            exp_we3     = 1'b0;
            exp_wa3     = '0;
            exp_wd3     = '0;
            exp_rx_data = '0;
            m_wait      = 1'b0;
            m_since     = 0;
            exp_q.delete();
        end else begin
            chk("we3", we3, exp_we3);
            chk("wa3", wa3, exp_wa3);
            chk("wd3", wd3, exp_wd3);
            if (we3) n_write++;
            exp_we3 = 1'b0;
            if (m_wait) m_since++;
            if (m_wait && m_since >= TO) m_wait = 1'b0;
            if (rx_valid || frame_err) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_pulse", {rx_valid, frame_err}, 32'd0);
                end else begin
                    ev = exp_q.pop_front();
                    chk("pulse_kind", {rx_valid, frame_err}, ev[8] ? 32'd1 : 32'd2);
                    if (!ev[8]) begin
                        n_valid++;
                        exp_rx_data = ev[7:0];
                        if (m_wait) begin
                            exp_we3 = 1'b1;
                            exp_wa3 = m_addr;
                            exp_wd3 = ev[7:0];
                            m_wait  = 1'b0;
                        end else if (ev[7]) begin
                            m_wait  = 1'b1;
                            m_addr  = ev[2:0];
                            m_since = 0;
                        end
                    end else begin
                        n_err++;
                        m_wait = 1'b0;
                    end
                end
            end
            chk("rx_data", rx_data, exp_rx_data);
        end
    end

    task automatic hold(input logic v, input int n);
        #1 rx = v;
        repeat (n) @(posedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stop_ok);
        exp_q.push_back({~stop_ok, b});
        hold(1'b0, BIT_CLK);
        for (int i = 0; i < 8; i++) hold(b[i], BIT_CLK);
        hold(stop_ok, BIT_CLK);
        hold(1'b1, 20);
        chk("frame_done", exp_q.size(), 32'd0);
    endtask

    initial begin
        int v0;
        logic [7:0] rb;
        logic [7:0] part;

        rst = 1'b0;
        rx  = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("rst_we3_wa3_wd3", {we3, wa3, wd3}, 32'd0);
        chk("rst_rx_data", rx_data, 32'd0);
        chk("rst_pulses_busy", {rx_valid, frame_err, busy}, 32'd0);
        rst = 1'b1;
        hold(1'b1, 2000);
        chk("idle_busy", busy, 32'd0);
        chk("idle_pulses", n_valid + n_err + n_write, 32'd0);

        send_byte(8'h85, 1'b1);
        send_byte(8'hA5, 1'b1);
        hold(1'b1, 5);
        chk("cmd1_valid_cnt", n_valid, 32'd2);
        chk("cmd1_write_cnt", n_write, 32'd1);
        chk("cmd1_wa3", wa3, 32'd5);
        chk("cmd1_wd3", wd3, 32'hA5);
        chk("cmd1_rx_data", rx_data, 32'hA5);

        hold(1'b0, 30);
        chk("glitch_busy_hi", busy, 32'd1);
        hold(1'b0, 10);
        hold(1'b1, 200);
        chk("glitch_busy_lo", busy, 32'd0);
        chk("glitch_no_pulse", n_valid + n_err, 32'd2);

        send_byte(8'h83, 1'b1);
        send_byte(8'h12, 1'b0);
        chk("ferr_cnt", n_err, 32'd1);
        chk("ferr_no_write", n_write, 32'd1);
        chk("ferr_rx_data", rx_data, 32'h83);
        send_byte(8'h81, 1'b1);
        send_byte(8'h7E, 1'b1);
        hold(1'b1, 5);
        chk("cmd2_write_cnt", n_write, 32'd2);
        chk("cmd2_wa3", wa3, 32'd1);
        chk("cmd2_wd3", wd3, 32'h7E);

        send_byte(8'h05, 1'b1);
        send_byte(8'h33, 1'b1);
        chk("nomark_valid_cnt", n_valid, 32'd7);
        chk("nomark_write_cnt", n_write, 32'd2);

        send_byte(8'h82, 1'b1);
        hold(1'b1, 5000);
        send_byte(8'h11, 1'b1);
        hold(1'b1, 5);
        chk("timeout_no_write", n_write, 32'd2);
        chk("timeout_wd3_kept", wd3, 32'h7E);

        for (int k = 0; k < 16; k++) begin
            rb = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 1) == 1) rb[7] = 1'b1;
            send_byte(rb, $urandom_range(0, 9) != 0);
            hold(1'b1, $urandom_range(0, 30));
        end

        v0   = n_valid;
        part = 8'h5A;
        hold(1'b0, BIT_CLK);
        for (int i = 0; i < 4; i++) hold(part[i], BIT_CLK);
        #1 rst = 1'b0;
        hold(1'b0, 3);
        #1;
        chk("midrst_outputs", {we3, wa3, wd3, rx_data, rx_valid, frame_err, busy}, 32'd0);
        hold(1'b1, 20);
        #1 rst = 1'b1;
        hold(1'b1, 2000);
        chk("midrst_no_pulse", n_valid, v0);
        chk("midrst_busy", busy, 32'd0);
        send_byte(8'h87, 1'b1);
        send_byte(8'h5A, 1'b1);
        hold(1'b1, 5);
        chk("post_rst_wa3", wa3, 32'd7);
        chk("post_rst_wd3", wd3, 32'h5A);

        chk("queue_drained", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
